ula_arb: RTL and testbench

ULA_ARB -- requirements
Module: ula_arb

---
 rtl/ula_pkg.sv | 16 +
 rtl/ula_arb.sv | 196 +++++++++++++++++++
 tb/tb_ula_arb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Processor parameters shared by the ALU and its arbiter wrapper.
package ula_pkg;

  localparam int unsigned DATA_WIDTH   = 16;
  localparam int unsigned OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] ADD = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] SUB = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] CMP = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] MUL = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] DIV = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] AND = 4'd5;
  localparam logic [OPCODE_WIDTH-1:0] OR  = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] NOT = 4'd7;

endpackage

// File: rtl/ula_arb.sv
// ula: combinational ALU. ula_arb: two-port arbiter that owns a single ula,
// latches the winning request, runs it (multi-cycle for MUL/DIV) and returns
// a registered result with a one-cycle valid pulse to the owner.
// Optional build macro: ULA_ARB_RR_EN selects round-robin arbitration;
// otherwise req0 has fixed priority over req1.
// Flags: [4] overflow, [3] greater, [2] equal, [1] less, [0] divide-by-zero.
module ula
  import ula_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [DATA_WIDTH-1:0]   res,
  output logic [4:0]              flags
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] prod;
  logic [W:0]           prod_top;

  // Opcode decode; ADD/SUB/MUL overflow is signed, CMP/DIV are unsigned.
  always_comb begin
    res      = '0;
    flags    = '0;
    prod     = PW'($signed(a)) * PW'($signed(b));
    prod_top = prod[PW-1:W-1];
    case (op)
      ADD: begin
        res      = a + b;
        flags[4] = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      SUB: begin
        res      = a - b;
        flags[4] = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      CMP: begin
        res      = a - b;
        flags[3] = a > b;
        flags[2] = a == b;
        flags[1] = a < b;
      end
      MUL: begin
        res      = prod[W-1:0];
        flags[4] = !((&prod_top) || !(|prod_top));
      end
      DIV: begin
        if (b == '0) begin
          flags[0] = 1'b1;
        end else begin
          res = a / b;
        end
      end
      AND:     res = a & b;
      OR:      res = a | b;
      NOT:     res = ~a;
      default: res = '0;
    endcase
  end

endmodule

module ula_arb
  import ula_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0,
  input  logic [OPCODE_WIDTH-1:0] op0,
  input  logic [DATA_WIDTH-1:0]   a0,
  input  logic [DATA_WIDTH-1:0]   b0,
  output logic                    gnt0,
  output logic                    valid0,
  input  logic                    req1,
  input  logic [OPCODE_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0]   a1,
  input  logic [DATA_WIDTH-1:0]   b1,
  output logic                    gnt1,
  output logic                    valid1,
  output logic [DATA_WIDTH-1:0]   out,
  output logic [4:0]              rflags,
  output logic                    busy
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  state;
  logic                    owner;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [CW-1:0]           cnt;
  logic                    win;
  logic                    any_req;
  logic                    is_md;
  logic                    last_cyc;
  logic [DATA_WIDTH-1:0]   ula_res;
  logic [4:0]              ula_flags;
`ifdef ULA_ARB_RR_EN
  logic                    rr_ptr;
`endif

  // Winner select: port 1 wins only when port 0 is idle, unless round-robin
  // hands a tie to the port that was not granted last.
  always_comb begin
    any_req = req0 | req1;
    win     = ~req0;
`ifdef ULA_ARB_RR_EN
    if (req0 && req1) begin
      win = ~rr_ptr;
    end
`endif
  end

  assign is_md    = (op_q == MUL) || (op_q == DIV);
  assign last_cyc = !is_md || (cnt == CW'(MULDIV_CYCLES - 1));

  ula u_ula (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .res   (ula_res),
    .flags (ula_flags)
  );

  // Control FSM with registered grant/valid pulses and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      out    <= '0;
      rflags <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      busy   <= 1'b0;
`ifdef ULA_ARB_RR_EN
      rr_ptr <= 1'b1;
`endif
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= EXEC;
            busy  <= 1'b1;
            owner <= win;
            op_q  <= win ? op1 : op0;
            a_q   <= win ? a1 : a0;
            b_q   <= win ? b1 : b0;
            cnt   <= '0;
            gnt0  <= ~win;
            gnt1  <= win;
`ifdef ULA_ARB_RR_EN
            rr_ptr <= win;
`endif
          end
        end
        EXEC: begin
          if (last_cyc) begin
            out    <= ula_res;
            rflags <= ula_flags;
            cnt    <= '0;
            valid0 <= ~owner;
            valid1 <= owner;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arb.sv
// Directed bench for ula_arb (DATA_WIDTH=16, MULDIV_CYCLES=4); honours
// ULA_ARB_RR_EN for the arbitration expectations.
module tb_ula_arb;
  import ula_pkg::*;

  localparam int unsigned MD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, valid0, valid1, busy;
  logic [15:0] out;
  logic [4:0]  rflags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_arb #(.MULDIV_CYCLES(MD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .op0    (op0),
    .a0     (a0),
    .b0     (b0),
    .gnt0   (gnt0),
    .valid0 (valid0),
    .req1   (req1),
    .op1    (op1),
    .a1     (a1),
    .b1     (b1),
    .gnt1   (gnt1),
    .valid1 (valid1),
    .out    (out),
    .rflags (rflags),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (p == 0) begin
      req0 = r; op0 = op; a0 = a; b0 = b;
    end else begin
      req1 = r; op1 = op; a1 = a; b1 = b;
    end
  endtask

  // One request on port p from IDLE; latency counts edges from the accept
  // edge to the edge at which valid is first seen high.
  task automatic run_op(input string tag, input int p, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                        input logic [15:0] exp_out, input logic [4:0] exp_fl);
    int  n;
    logic got;
    drive(p, 1'b1, op, a, b);
    step();
    chk({tag, "_gnt"}, 32'(p == 0 ? gnt0 : gnt1), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    drive(p, 1'b0, op, a, b);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      step();
      n++;
      if (p == 0 ? valid0 : valid1) got = 1'b1;
    end
    chk({tag, "_lat"}, 32'(n + 1), 32'(exp_lat));
    chk({tag, "_out"}, 32'(out), 32'(exp_out));
    chk({tag, "_rflags"}, 32'(rflags), 32'(exp_fl));
    step();
    chk({tag, "_valid_pulse"}, 32'(valid0 | valid1), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   exp_win [4];
    int   n;
    int   vcount;
    logic last_win;

`ifdef ULA_ARB_RR_EN
    exp_win = '{0, 1, 0, 1};
`else
    exp_win = '{0, 0, 0, 0};
`endif

    // Reset state
    #3;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_rflags", 32'(rflags), 32'd0);
    chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("rst_valid", 32'({valid0, valid1}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #9 rst_n = 1'b1;
    step();

    run_op("add_p0", 0, ADD, 16'd5, 16'd7, 2, 16'd12, 5'b00000);
    run_op("cmp_lt_p1", 1, CMP, 16'd3, 16'd9, 2, 16'hFFFA, 5'b00010);
    run_op("cmp_eq_p1", 1, CMP, 16'd9, 16'd9, 2, 16'd0, 5'b00100);
    run_op("mul_ovf_p0", 0, MUL, 16'h4000, 16'd2, MD + 1, 16'h8000, 5'b10000);
    run_op("div0_p1", 1, DIV, 16'd7, 16'd0, MD + 1, 16'd0, 5'b00001);
    run_op("undef_p1", 1, 4'hF, 16'h1234, 16'h5678, 2, 16'd0, 5'b00000);

    // Both requests held continuously across four grants
    drive(0, 1'b1, ADD, 16'd1, 16'd1);
    drive(1, 1'b1, ADD, 16'd2, 16'd2);
    last_win = 1'b0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(gnt0 || gnt1) && n < 20) begin
        step();
        n++;
      end
      chk("arb_grant_seen", 32'(gnt0 | gnt1), 32'd1);
      chk("arb_winner", 32'(gnt1), 32'(exp_win[g]));
      last_win = gnt1;
      step();
    end
    drive(0, 1'b0, ADD, 16'd1, 16'd1);
    drive(1, 1'b0, ADD, 16'd2, 16'd2);
    chk("arb_last_valid", 32'(last_win ? valid1 : valid0), 32'd1);
    chk("arb_last_out", 32'(out), last_win ? 32'd4 : 32'd2);
    step();

    // Result holds while idle
    step();
    step();
    step();
    chk("hold_out", 32'(out), last_win ? 32'd4 : 32'd2);

    // Request raised mid-operation is served at the first IDLE edge
    drive(0, 1'b1, ADD, 16'd8, 16'd8);
    step();
    chk("late_gnt0", 32'(gnt0), 32'd1);
    drive(0, 1'b0, ADD, 16'd8, 16'd8);
    drive(1, 1'b1, SUB, 16'd10, 16'd3);
    n = 0;
    while (!gnt1 && n < 20) begin
      step();
      n++;
    end
    chk("late_req_edges", 32'(n), 32'd3);
    drive(1, 1'b0, SUB, 16'd10, 16'd3);
    n = 0;
    while (!valid1 && n < 20) begin
      step();
      n++;
    end
    chk("late_sub_out", 32'(out), 32'd7);
    step();

    // Reset during the second EXEC cycle of a DIV
    drive(0, 1'b1, DIV, 16'd100, 16'd7);
    step();
    chk("rdiv_gnt", 32'(gnt0), 32'd1);
    drive(0, 1'b0, DIV, 16'd100, 16'd7);
    step();
    chk("rdiv_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rdiv_out", 32'(out), 32'd0);
    chk("rdiv_rflags", 32'(rflags), 32'd0);
    chk("rdiv_busy_clr", 32'(busy), 32'd0);
    chk("rdiv_gv", 32'({gnt0, gnt1, valid0, valid1}), 32'd0);
    #2 rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid0 || valid1) vcount++;
    end
    chk("rdiv_no_valid", 32'(vcount), 32'd0);
    run_op("post_rst_add", 0, ADD, 16'd20, 16'd22, 2, 16'd42, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
